qrd_row_skewer: RTL and testbench

QRD_ROW_SKEWER -- requirements
Module: qrd_row_skewer

---
 rtl/qrd_row_skewer.sv | 89 ++++++++
 tb/tb_qrd_row_skewer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/qrd_row_skewer.sv
// qrd_row_skewer: row FIFO feeding a diagonally skewed lane pipeline for a QR array (zero-bubble option: QRD_SKEW_ZERO_BUBBLE_EN)
module qrd_row_skewer #(
    parameter int N           = 5,
    parameter int DATA_LENGTH = 8,
    parameter int DEPTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*DATA_LENGTH-1:0]   in_row,
    input  logic                       in_last,
    output logic [N*DATA_LENGTH-1:0]   out_data,
    output logic [N-1:0]               out_valid,
    output logic                       done
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
    state_t state, state_nx;
    logic [N*DATA_LENGTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] mem_last;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic push, pop;
    logic [N-1:0] pipe_valid, pipe_last;
    assign in_ready  = !rst && (count < (AW+1)'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (count != '0) && (state != DRAIN);
    assign out_valid = pipe_valid;
    assign done      = pipe_valid[N-1] && pipe_last[N-1];
    // FIFO storage; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]      <= in_row;
            mem_last[wr_ptr] <= in_last;
        end
    end
    // FIFO pointers and occupancy; a pushed row is only visible to pop next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // DRAIN holds off pops until the last row exits lane N-1 (done), keeping blocks apart
    always_comb begin
        state_nx = state;
        if (state == DRAIN) state_nx = done ? IDLE : DRAIN;
        else if (pop) state_nx = mem_last[rd_ptr] ? DRAIN : STREAM;
    end
    // valid/last travel one lane per cycle; a cycle without pop injects a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_last  <= '0;
        end else begin
            pipe_valid <= (pipe_valid << 1) | N'(pop);
            pipe_last  <= (pipe_last << 1) | N'(pop && mem_last[rd_ptr]);
        end
    end
    // lane k delays its own element k times more than lane 0; data only moves with valid so bubbles hold
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [DATA_LENGTH-1:0] d [k+1];
        // per-lane delay chain
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i <= k; i++) d[i] <= '0;
            end else begin
                if (pop) d[0] <= mem[rd_ptr][k*DATA_LENGTH +: DATA_LENGTH];
                for (int i = 1; i <= k; i++) if (pipe_valid[i-1]) d[i] <= d[i-1];
            end
        end
`ifdef QRD_SKEW_ZERO_BUBBLE_EN
        assign out_data[k*DATA_LENGTH +: DATA_LENGTH] = pipe_valid[k] ? d[k] : '0;
`else
        assign out_data[k*DATA_LENGTH +: DATA_LENGTH] = d[k];
`endif
    end
endmodule

// File: tb/tb_qrd_row_skewer.sv
// tb_qrd_row_skewer: directed checks of the row skewer (FIFO, skew timing, drain, bubbles, reset)
module tb_qrd_row_skewer;
    localparam int N  = 5;
    localparam int DL = 8;
`ifdef QRD_SKEW_ZERO_BUBBLE_EN
    localparam bit ZB = 1'b1;
`else
    localparam bit ZB = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0;
    logic [N*DL-1:0] in_row = '0;
    logic in_ready, done;
    logic [N*DL-1:0] out_data;
    logic [N-1:0] out_valid;
    int checks = 0, failures = 0;
    int p;
    logic acc, l0;
    always #5 clk = ~clk;
    qrd_row_skewer #(.N(N), .DATA_LENGTH(DL), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .in_last(in_last), .out_data(out_data), .out_valid(out_valid), .done(done)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [N*DL-1:0] mk_row(input logic [7:0] base);
        logic [N*DL-1:0] r;
        for (int k = 0; k < N; k++) r[k*DL +: DL] = base + 8'(k);
        return r;
    endfunction
    function automatic logic [7:0] lane(input int k);
        return out_data[k*DL +: DL];
    endfunction
    initial begin
        tick;
        tick;
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("first_ready", in_ready, 1);
        for (int c = 0; c < 8; c++) begin
            chk("t1_valid", out_valid, (c >= 2 && c <= 6) ? (1 << (c - 2)) : 0);
            if (c >= 2 && c <= 6) chk("t1_data", lane(c - 2), 8'h10 + 8'(c - 2));
            chk("t1_done", done, 0);
            in_valid = (c == 0);
            in_row   = mk_row(8'h10);
            in_last  = 1'b0;
            tick;
        end
        p = 0;
        for (int c = 0; c < 14; c++) begin
            chk("t2_ready", in_ready, (c <= 8 || c >= 12));
            l0 = (c >= 2 && c <= 6) || c >= 12;
            chk("t2_lane0_valid", out_valid[0], l0);
            if (l0) chk("t2_lane0_data", lane(0), 8'h40 + 8'(8 * (c <= 6 ? c - 2 : c - 7)));
            chk("t2_lane4_valid", out_valid[4], c >= 6 && c <= 10);
            if (c >= 6 && c <= 10) chk("t2_lane4_data", lane(4), 8'h44 + 8'(8 * (c - 6)));
            chk("t2_done", done, c == 10);
            in_valid = 1'b1;
            in_row   = mk_row(8'h40 + 8'(8 * p));
            in_last  = (p == 4);
            acc      = in_ready;
            tick;
            if (acc) p++;
        end
        chk("t2_accepted", p, 11);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (20) tick;
        for (int c = 0; c < 11; c++) begin
            for (int k = 0; k < N; k++) begin
                if (c == 2 + k) begin
                    chk("gap_a_valid", out_valid[k], 1);
                    chk("gap_a_data", lane(k), 8'h60 + 8'(k));
                end else if (c == 5 + k) begin
                    chk("gap_b_valid", out_valid[k], 1);
                    chk("gap_b_data", lane(k), 8'h70 + 8'(k));
                end else if (c == 3 + k || c == 4 + k) begin
                    chk("gap_bubble_valid", out_valid[k], 0);
                    chk("gap_bubble_data", lane(k), ZB ? 8'h00 : 8'h60 + 8'(k));
                end
            end
            in_valid = (c == 0 || c == 3);
            in_row   = mk_row(c == 0 ? 8'h60 : 8'h70);
            tick;
        end
        in_valid = 1'b0;
        repeat (8) tick;
        in_valid = 1'b1;
        in_row   = mk_row(8'hA0);
        tick;
        in_row   = mk_row(8'hB0);
        in_last  = 1'b1;
        tick;
        in_last  = 1'b0;
        in_row   = mk_row(8'hD0);
        tick;
        in_row   = mk_row(8'hD8);
        tick;
        in_row   = mk_row(8'hE0);
        tick;
        chk("r_ready_before", in_ready, 1);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("r_ready_in_rst", in_ready, 0);
        tick;
        rst = 1'b0;
        #1;
        chk("r_valid_after", out_valid, 0);
        chk("r_data_after", out_data, 0);
        chk("r_ready_after", in_ready, 1);
        for (int c = 6; c < 17; c++) begin
            chk("r_done", done, 0);
            chk("r_valid", out_valid, (c >= 8 && c <= 12) ? (1 << (c - 8)) : 0);
            if (c == 8) chk("r_lane0_data", lane(0), 8'hC0);
            in_valid = (c == 6);
            in_row   = mk_row(8'hC0);
            tick;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
